// File: rtl/uart_vector_multiplier_pkg.sv
// Shared defaults, bit-time constant and state encodings for the UART vector multiplier.
package uart_vector_multiplier_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int N_DEF     = 2;
    localparam int IF_DEF    = 2;
    localparam int UF_DEF    = 1;
    localparam int BIT_CLKS  = IF_DEF / UF_DEF;

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_SEND, S_WAIT} vm_state_e;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
endpackage

// File: rtl/uart_vector_multiplier_if.sv
// Serial link bundle: host drives rx, engine drives tx and busy.
interface uart_vector_multiplier_if;
    logic rx;
    logic tx;
    logic busy;

    modport slave  (input rx, output tx, output busy);
    modport master (output rx, input tx, input busy);
endinterface

// File: rtl/uart_vector_multiplier_rx.sv
// UART receiver: 1 start, W data bits LSB first, 1 stop; one-clock valid per good frame.
module uart_rx_core
    import uart_vector_multiplier_pkg::*;
#(
    parameter int W  = WIDTH_DEF,
    parameter int IF = IF_DEF,
    parameter int UF = UF_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    localparam int BC   = IF / UF;
    localparam int HALF = BC / 2;
    localparam int CW   = (BC > 1) ? $clog2(BC) : 1;
    localparam int BW   = (W > 1) ? $clog2(W) : 1;

    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_q;
    logic [W-1:0]  data_q;
    logic          rx_prev_q;
    logic          valid_q;

    // Edge detect, mid-bit sampling and stop-bit check; a low stop bit drops the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= U_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            rx_prev_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            rx_prev_q <= rx_i;
            valid_q   <= 1'b0;
            case (state_q)
                U_IDLE: if (rx_prev_q && !rx_i) begin
                    cnt_q   <= '0;
                    state_q <= U_START;
                end
                U_START: if (cnt_q == CW'(HALF - 1)) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= rx_i ? U_IDLE : U_DATA;
                end else cnt_q <= cnt_q + 1'b1;
                U_DATA: if (cnt_q == CW'(BC - 1)) begin
                    cnt_q  <= '0;
                    data_q <= {rx_i, data_q[W-1:1]};
                    if (bit_q == BW'(W - 1)) state_q <= U_STOP;
                    else bit_q <= bit_q + 1'b1;
                end else cnt_q <= cnt_q + 1'b1;
                U_STOP: if (cnt_q == CW'(BC - 1)) begin
                    cnt_q   <= '0;
                    valid_q <= rx_i;
                    state_q <= U_IDLE;
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= U_IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/uart_vector_multiplier_tx.sv
// UART transmitter: start, W data bits LSB first, stop; busy covers the whole frame.
module uart_tx_core
    import uart_vector_multiplier_pkg::*;
#(
    parameter int W  = 2 * WIDTH_DEF,
    parameter int IF = IF_DEF,
    parameter int UF = UF_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] data_i,
    output logic         tx_o,
    output logic         busy_o
);
    localparam int BC = IF / UF;
    localparam int CW = (BC > 1) ? $clog2(BC) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_q;
    logic [W-1:0]  sh_q;
    logic          tx_q;
    logic          busy_q;

    // Frame sequencer; start is only honoured while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                U_IDLE: if (start_i) begin
                    sh_q    <= data_i;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= U_START;
                end
                U_START: if (cnt_q == CW'(BC - 1)) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= sh_q[0];
                    state_q <= U_DATA;
                end else cnt_q <= cnt_q + 1'b1;
                U_DATA: if (cnt_q == CW'(BC - 1)) begin
                    cnt_q <= '0;
                    if (bit_q == BW'(W - 1)) begin
                        tx_q    <= 1'b1;
                        state_q <= U_STOP;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                        sh_q  <= sh_q >> 1;
                        tx_q  <= sh_q[1];
                    end
                end else cnt_q <= cnt_q + 1'b1;
                U_STOP: if (cnt_q == CW'(BC - 1)) begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= U_IDLE;
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= U_IDLE;
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
endmodule

// File: rtl/uart_vector_multiplier.sv
// Loads A and B over UART, multiplies element-wise, returns the products over UART.
module uart_vector_multiplier
    import uart_vector_multiplier_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IF    = IF_DEF,
    parameter int UF    = UF_DEF
) (
    input  logic clk,
    input  logic rst,
    uart_vector_multiplier_if.slave bus
);
    localparam int KW = $clog2(2 * N);
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    vm_state_e                 state_q;
    logic [KW-1:0]             k_q;
    logic [JW-1:0]             j_q;
    logic [JW-1:0]             j_nx;
    logic [N-1:0][WIDTH-1:0]   a_q, b_q;
    logic [N-1:0][PW-1:0]      p_q, prod_d;
    logic [PW-1:0]             tx_data_q;
    logic                      tx_start_q;
    logic                      busy_q;
    logic                      rx_valid;
    logic [WIDTH-1:0]          rx_data;
    logic                      tx_busy;

    uart_rx_core #(.W(WIDTH), .IF(IF), .UF(UF)) u_rx (
        .clk(clk), .rst(rst), .rx_i(bus.rx), .valid_o(rx_valid), .data_o(rx_data)
    );

    uart_tx_core #(.W(PW), .IF(IF), .UF(UF)) u_tx (
        .clk(clk), .rst(rst), .start_i(tx_start_q), .data_i(tx_data_q),
        .tx_o(bus.tx), .busy_o(tx_busy)
    );

    // Full-width element-wise products, captured in CALC.
    always_comb begin
        for (int i = 0; i < N; i++)
            prod_d[i] = PW'(a_q[i]) * PW'(b_q[i]);
    end

    assign j_nx = j_q + 1'b1;

    // Control FSM; after a frame completes the next start is issued straight from WAIT
    // so consecutive result frames are separated by only two mark clocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            k_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_LOAD: if (rx_valid) begin
                    if (k_q < KW'(N)) a_q[JW'(k_q)] <= rx_data;
                    else b_q[JW'(k_q - KW'(N))] <= rx_data;
                    busy_q <= 1'b1;
                    if (k_q == KW'(2 * N - 1)) begin
                        k_q     <= '0;
                        state_q <= S_CALC;
                    end else k_q <= k_q + 1'b1;
                end
                S_CALC: begin
                    p_q        <= prod_d;
                    tx_data_q  <= prod_d[0];
                    tx_start_q <= 1'b1;
                    j_q        <= '0;
                    state_q    <= S_SEND;
                end
                S_SEND: state_q <= S_WAIT;
                S_WAIT: if (!tx_busy) begin
                    if (j_q == JW'(N - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_LOAD;
                    end else begin
                        j_q        <= j_nx;
                        tx_data_q  <= p_q[j_nx];
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_vector_multiplier.sv
// Randomised and directed bench with a queue-based model of the vector engine.
module tb_uart_vector_multiplier;
    localparam int N = 2;
    localparam int W = 8;
    localparam int B = uart_vector_multiplier_pkg::BIT_CLKS;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   elems[$];
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] log_q[$];
    bit   sending_byte;

    uart_vector_multiplier_if bus();

    uart_vector_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (B) @(negedge clk);
    endtask

    // Model: a byte is taken only when no results are pending and its stop bit is good.
    task automatic send_byte(input int d, input bit bad_stop);
        logic [W-1:0] v;
        v = W'(d);
        sending_byte = 1'b1;
        if (!bad_stop && exp_q.size() == 0) begin
            elems.push_back(d);
            if (elems.size() == 2 * N) begin
                for (int i = 0; i < N; i++)
                    exp_q.push_back((2*W)'(elems[i] * elems[N+i]));
                elems.delete();
            end
        end
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(v[i]);
        drive_bit(bad_stop ? 1'b0 : 1'b1);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        sending_byte = 1'b0;
    endtask

    task automatic send4(input int a0, input int a1, input int b0, input int b1);
        send_byte(a0, 0);
        send_byte(a1, 0);
        send_byte(b0, 0);
        send_byte(b1, 0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("set_done_in_time", t < 4000, 1);
    endtask

    // Output decoder: checks every result frame, its stop bit, busy and inter-frame gap.
    initial begin : mon
        logic [2*W-1:0] sh;
        logic [2*W-1:0] e;
        int gap;
        forever begin
            if (!(rst === 1'b1 && bus.tx === 1'b0)) @(negedge clk);
            else begin
                for (int i = 0; i < 2 * W; i++) begin
                    repeat (B) @(negedge clk);
                    sh[i] = bus.tx;
                    chk("busy_in_frame", bus.busy, 1);
                end
                repeat (B) @(negedge clk);
                chk("stop_bit", bus.tx, 1);
                log_q.push_back(sh);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("product", sh, e);
                end
                if (exp_q.size() != 0) begin
                    gap = 0;
                    do begin
                        @(negedge clk);
                        gap++;
                    end while (bus.tx !== 1'b0 && gap < 50);
                    chk("frame_gap", gap <= B + 2, 1);
                end
            end
        end
    end

    // Whenever the model has nothing loaded or pending, the link must be quiet.
    initial begin : idlechk
        int idle_cnt;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (elems.size() == 0 && exp_q.size() == 0 && !sending_byte) idle_cnt++;
            else idle_cnt = 0;
            if (idle_cnt > B + 4) begin
                chk("idle_busy", bus.busy, 0);
                chk("idle_tx", bus.tx, 1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int t;
        int r[4];
        bus.rx = 1'b1;
        rst = 1'b0;
        sending_byte = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_tx", bus.tx, 1);
        chk("reset_busy", bus.busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // nominal
        base = log_q.size();
        send_byte(45, 0);
        chk("busy_after_first", bus.busy, 1);
        send_byte(5, 0);
        send_byte(97, 0);
        send_byte(3, 0);
        chk("busy_after_last", bus.busy, 1);
        wait_done();
        chk("nom_p0", log_q[base], 16'h110D);
        chk("nom_p1", log_q[base+1], 16'h000F);
        chk("nom_busy_low", bus.busy, 0);

        // maximum operands
        base = log_q.size();
        send4(255, 255, 255, 1);
        wait_done();
        chk("max_p0", log_q[base], 16'hFE01);
        chk("max_p1", log_q[base+1], 16'h00FF);

        // framing error on the second byte
        base = log_q.size();
        send_byte(10, 0);
        send_byte(20, 1);
        send4(30, 40, 50, 0);
        elems.delete();
        wait_done();
        chk("frm_p0", log_q[base], 16'd400);
        chk("frm_p1", log_q[base+1], 16'd1500);

        // reset mid-operation
        send_byte(1, 0);
        send_byte(2, 0);
        send_byte(3, 0);
        rst = 1'b0;
        elems.delete();
        @(negedge clk);
        chk("rst_mid_tx", bus.tx, 1);
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", bus.busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        base = log_q.size();
        send4(45, 5, 97, 3);
        wait_done();
        chk("rst_p0", log_q[base], 16'h110D);
        chk("rst_p1", log_q[base+1], 16'h000F);

        // overrun while results are being sent
        send4(11, 12, 13, 14);
        t = 0;
        while (bus.tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ovr_first_frame_started", t < 200, 1);
        send_byte(7, 0);
        wait_done();
        base = log_q.size();
        send4(2, 3, 4, 5);
        wait_done();
        chk("ovr_p0", log_q[base], 16'd8);
        chk("ovr_p1", log_q[base+1], 16'd15);

        // back-to-back random sets
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 255));
            send4(r[0], r[1], r[2], r[3]);
            wait_done();
        end

        repeat (20) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
